// File: rtl/fifo4_pkg.sv
// Shared sizing and types for the four-entry, 4-bit nibble FIFO and its read mux.
package fifo4_pkg;

    localparam int FIFO_DEPTH = 4;
    localparam int DATA_W     = 4;
    localparam int PTR_W      = 2;
    localparam int CNT_W      = 3;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [CNT_W-1:0]  cnt_t;

endpackage : fifo4_pkg

// File: rtl/Mux4_4b_RTL.sv
// Four-to-one, 4-bit read mux; picks one FIFO storage register by the read pointer.
module Mux4_4b_RTL
    import fifo4_pkg::*;
(
    input  data_t in0,
    input  data_t in1,
    input  data_t in2,
    input  data_t in3,
    input  ptr_t  sel,
    output data_t out
);

    always_comb begin
        out = in0;
        case (sel)
            2'd0:    out = in0;
            2'd1:    out = in1;
            2'd2:    out = in2;
            2'd3:    out = in3;
            default: out = in0;
        endcase
    end

endmodule : Mux4_4b_RTL

// File: rtl/fifo4_4b.sv
// Four-entry, 4-bit valid/ready FIFO; handshake outputs are registered decodes of
// the occupancy counter, so there is no path from enqueue side to dequeue side.
module fifo4_4b
    import fifo4_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enq_val,
    output logic       enq_rdy,
    input  data_t      enq_data,
    output logic       deq_val,
    input  logic       deq_rdy,
    output data_t      deq_data,
    output logic [2:0] count
);

    data_t                 r_mem [FIFO_DEPTH];
    ptr_t                  r_wptr;
    ptr_t                  r_rptr;
    cnt_t                  r_cnt;

    logic                  w_enq_fire;
    logic                  w_deq_fire;
    logic [FIFO_DEPTH-1:0] w_we;

    assign enq_rdy    = (r_cnt != CNT_W'(FIFO_DEPTH));
    assign deq_val    = (r_cnt != '0);
    assign count      = r_cnt;
    assign w_enq_fire = enq_val & enq_rdy;
    assign w_deq_fire = deq_val & deq_rdy;

    always_comb begin
        w_we = '0;
        if (w_enq_fire) begin
            w_we[r_wptr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (w_we[i]) begin
                    r_mem[i] <= enq_data;
                end
            end
        end
    end

    // Pointers are exactly PTR_W bits wide so they wrap 3 -> 0 for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_enq_fire) begin
                r_wptr <= r_wptr + 2'd1;
            end
            if (w_deq_fire) begin
                r_rptr <= r_rptr + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            case ({w_enq_fire, w_deq_fire})
                2'b10:   r_cnt <= r_cnt + 3'd1;
                2'b01:   r_cnt <= r_cnt - 3'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    Mux4_4b_RTL u_readMux (
        .in0 (r_mem[0]),
        .in1 (r_mem[1]),
        .in2 (r_mem[2]),
        .in3 (r_mem[3]),
        .sel (r_rptr),
        .out (deq_data)
    );

endmodule : fifo4_4b

// File: tb/tb_fifo4_4b.sv
// Scoreboard bench for fifo4_4b: a queue of accepted nibbles is the reference
// for handshakes, occupancy, head data and output order.
module tb_fifo4_4b;

    logic       clk;
    logic       rst_n;
    logic       enq_val;
    logic       enq_rdy;
    logic [3:0] enq_data;
    logic       deq_val;
    logic       deq_rdy;
    logic [3:0] deq_data;
    logic [2:0] count;

    logic [3:0] scoreQ [$];
    int         checkCount;
    int         passCount;

    fifo4_4b dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enq_val  (enq_val),
        .enq_rdy  (enq_rdy),
        .enq_data (enq_data),
        .deq_val  (deq_val),
        .deq_rdy  (deq_rdy),
        .deq_data (deq_data),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0h, expected %0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Called just after a rising edge: checks the pre-edge outputs against the
    // scoreboard, retires the head if a dequeue fires, then clocks once.
    task automatic applyStimulus(input logic ev, input logic [3:0] ed, input logic dr);
        logic expEnq;
        logic expDeq;
        enq_val  = ev;
        enq_data = ed;
        deq_rdy  = dr;
        expEnq = ev && (scoreQ.size() < 4);
        expDeq = dr && (scoreQ.size() > 0);
        checkOutput("enqRdy", 8'(enq_rdy), 8'(scoreQ.size() != 4));
        checkOutput("deqVal", 8'(deq_val), 8'(scoreQ.size() != 0));
        if (scoreQ.size() > 0) begin
            checkOutput("deqData", 8'(deq_data), 8'(scoreQ[0]));
        end
        if (expDeq) begin
            void'(scoreQ.pop_front());
        end
        @(posedge clk);
        #1;
        if (expEnq) begin
            scoreQ.push_back(ed);
        end
        checkOutput("count", 8'(count), 8'(scoreQ.size()));
        checkOutput("cntBound", 8'(count <= 3'd4), 8'd1);
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        rst_n    = 1'b0;
        enq_val  = 1'b0;
        enq_data = 4'h0;
        deq_rdy  = 1'b0;
        #2;
        checkOutput("rstCount", 8'(count), 8'd0);
        checkOutput("rstDeqVal", 8'(deq_val), 8'd0);
        checkOutput("rstEnqRdy", 8'(enq_rdy), 8'd1);
        checkOutput("rstDeqData", 8'(deq_data), 8'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fill with A..D while the consumer stalls.
        applyStimulus(1'b1, 4'hA, 1'b0);
        applyStimulus(1'b1, 4'hB, 1'b0);
        applyStimulus(1'b1, 4'hC, 1'b0);
        applyStimulus(1'b1, 4'hD, 1'b0);
        checkOutput("fullEnqRdy", 8'(enq_rdy), 8'd0);
        checkOutput("fullHead", 8'(deq_data), 8'hA);

        // Push F against a full FIFO; it must never appear in the drain.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'hF, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'h0, 1'b1);
        checkOutput("drainedDeqVal", 8'(deq_val), 8'd0);

        // Streaming through the wrap point, one in and one out per cycle.
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 4'(i), 1'b1);
        checkOutput("streamCount", 8'(count), 8'd1);
        applyStimulus(1'b0, 4'h0, 1'b1);

        // Empty: enqueue with deq_rdy high must not bypass.
        applyStimulus(1'b1, 4'h5, 1'b1);
        checkOutput("noBypassVal", 8'(deq_val), 8'd1);
        checkOutput("noBypassData", 8'(deq_data), 8'h5);
        applyStimulus(1'b0, 4'h0, 1'b1);

        // Full with both sides requesting: only the dequeue happens.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'(i + 8), 1'b0);
        applyStimulus(1'b1, 4'hE, 1'b1);
        checkOutput("fullBothCount", 8'(count), 8'd3);
        checkOutput("fullBothRdy", 8'(enq_rdy), 8'd1);
        checkOutput("fullBothHead", 8'(deq_data), 8'h9);

        // Asynchronous reset partway through a cycle with three entries held.
        enq_val = 1'b0;
        deq_rdy = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncRstCount", 8'(count), 8'd0);
        checkOutput("asyncRstDeqVal", 8'(deq_val), 8'd0);
        checkOutput("asyncRstEnqRdy", 8'(enq_rdy), 8'd1);
        checkOutput("asyncRstData", 8'(deq_data), 8'h0);
        scoreQ.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 4'h7, 1'b0);
        checkOutput("postRstData", 8'(deq_data), 8'h7);
        applyStimulus(1'b0, 4'h0, 1'b1);
        applyStimulus(1'b0, 4'h0, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule : tb_fifo4_4b
